// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider. Produces one quotient bit per clock
// from a single trial subtractor, computed as A + ~B + 1.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a division; sampled only while idle
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         high while a division is running or presenting its result
//   done         one-cycle pulse when quotient/remainder are final
//   quotient     result quotient (held until the next accepted start)
//   remainder    result remainder (held until the next accepted start)
//   div_by_zero  valid with done; set when the divisor was zero
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    // The partial remainder is always below the divisor between steps, so its
    // top bit is zero and only WIDTH bits are stored; the shifted trial operand
    // carries the full WIDTH+1 bits.
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // Trial subtraction. |shifted - divisor| < 2^WIDTH, so the sign of the
    // (WIDTH+1)-bit difference is exactly the borrow.
    always_comb begin
        shifted = {prem_q, quo_q[WIDTH-1]};
        diff    = shifted + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
        borrow  = diff[WIDTH];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        quo_d   = dividend;
                        dvs_d   = divisor;
                        prem_d  = '0;
                        count_d = CntW'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        quo_d   = '1;
                        prem_d  = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                quo_d   = {quo_q[WIDTH-2:0], ~borrow};
                // Restore: keep the shifted value when the trial borrowed.
                prem_d  = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        quotient    = quo_q;
        remainder   = prem_q;
        div_by_zero = dbz_q;
    end

endmodule
